line_buffer_win: RTL and testbench

- Parametrised single-line pixel buffer for the sliding-window convolution path; successor to the fixed 512-entry, 8-bit, 3-tap line store.
- Accepts one pixel per valid cycle until a full line of IMAGE_WIDTH pixels is stored. Then presents a registered WINDOW-tap horizontal window per read request.
- Explicit fill/drain handshake plus line-done strobes for the upstream multi-line controller. Non-power-of-two widths supported.

---
 rtl/line_buffer_pkg.sv | 18 +
 rtl/line_buffer_ram.sv | 23 ++
 rtl/line_buffer_win.sv | 75 +++++++
 tb/tb_line_buffer_win.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/line_buffer_pkg.sv
// line_buffer_pkg: shared state encoding, defaults and tap addressing for the line buffer
// Optional macro: LINEBUF_CLAMP_EN selects border-replicate tap addressing, otherwise taps wrap to the line start.
package line_buffer_pkg;
  typedef enum logic [1:0] {FILL = 2'd0, READY = 2'd1, DRAIN = 2'd2} state_t;
  localparam int DEF_PIXEL_W = 8;
  localparam int DEF_WINDOW = 3;
  localparam int DEF_IMAGE_WIDTH = 512;
`ifdef LINEBUF_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif
  // base+k never reaches 2*width, so one conditional subtract replaces a modulo
  function automatic int tap_addr(input int base, input int k, input int width);
    return CLAMP_EN ? ((base + k > width - 1) ? width - 1 : base + k)
                    : ((base + k >= width) ? base + k - width : base + k);
  endfunction
endpackage

// File: rtl/line_buffer_ram.sv
// line_buffer_ram: one-line pixel store, one synchronous write port, WINDOW asynchronous read ports
// Ports: i_clk clock; i_we/i_waddr/i_wdata write port; i_raddr packed read addresses (tap g in slice g);
// o_rdata packed read data with tap 0 at the MSBs.
module line_buffer_ram #(
  parameter int PIXEL_W = 8,
  parameter int IMAGE_WIDTH = 512,
  parameter int WINDOW = 3,
  parameter int ADDR_W = $clog2(IMAGE_WIDTH)
) (
  input  logic                      i_clk,
  input  logic                      i_we,
  input  logic [ADDR_W-1:0]         i_waddr,
  input  logic [PIXEL_W-1:0]        i_wdata,
  input  logic [WINDOW*ADDR_W-1:0]  i_raddr,
  output logic [WINDOW*PIXEL_W-1:0] o_rdata
);
  logic [PIXEL_W-1:0] mem [IMAGE_WIDTH];
  always_ff @(posedge i_clk)
    if (i_we) mem[i_waddr] <= i_wdata;
  for (genvar g = 0; g < WINDOW; g++) begin : g_rd
    assign o_rdata[(WINDOW-1-g)*PIXEL_W +: PIXEL_W] = mem[i_raddr[g*ADDR_W +: ADDR_W]];
  end
endmodule

// File: rtl/line_buffer_win.sv
// line_buffer_win: single-line pixel buffer presenting a registered WINDOW-tap horizontal window per read
// Ports: i_clk clock; i_rst async active-high reset; i_data_valid/i_data/o_wr_ready fill handshake;
// i_rd_data/o_rd_ready drain handshake; o_data window (tap 0 at MSBs) with o_data_valid;
// o_wr_line_done/o_rd_line_done one-cycle end-of-line strobes.
// Optional macro: LINEBUF_CLAMP_EN replicates the last pixel for taps past the line end instead of wrapping.
module line_buffer_win
  import line_buffer_pkg::*;
#(
  parameter int PIXEL_W = DEF_PIXEL_W,
  parameter int IMAGE_WIDTH = DEF_IMAGE_WIDTH,
  parameter int WINDOW = DEF_WINDOW,
  parameter int ADDR_W = $clog2(IMAGE_WIDTH)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_data_valid,
  input  logic [PIXEL_W-1:0]        i_data,
  output logic                      o_wr_ready,
  input  logic                      i_rd_data,
  output logic                      o_rd_ready,
  output logic [WINDOW*PIXEL_W-1:0] o_data,
  output logic                      o_data_valid,
  output logic                      o_wr_line_done,
  output logic                      o_rd_line_done
);
  state_t state, state_nx;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [WINDOW*ADDR_W-1:0] raddr;
  logic [WINDOW*PIXEL_W-1:0] rdata;
  logic wr_acc, rd_acc, wr_last, rd_last;
  assign wr_acc = state == FILL && i_data_valid;
  assign rd_acc = state != FILL && i_rd_data;
  assign wr_last = wr_ptr == ADDR_W'(IMAGE_WIDTH - 1);
  assign rd_last = rd_ptr == ADDR_W'(IMAGE_WIDTH - 1);
  for (genvar g = 0; g < WINDOW; g++) begin : g_tap
    assign raddr[g*ADDR_W +: ADDR_W] = ADDR_W'(tap_addr(int'(rd_ptr), g, IMAGE_WIDTH));
  end
  line_buffer_ram #(
    .PIXEL_W(PIXEL_W),
    .IMAGE_WIDTH(IMAGE_WIDTH),
    .WINDOW(WINDOW),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .i_clk(i_clk),
    .i_we(wr_acc),
    .i_waddr(wr_ptr),
    .i_wdata(i_data),
    .i_raddr(raddr),
    .o_rdata(rdata)
  );
  always_comb begin
    o_wr_ready = state == FILL;
    o_rd_ready = state != FILL;
    state_nx = wr_acc && wr_last ? READY : rd_acc && rd_last ? FILL : rd_acc ? DRAIN : state;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= FILL;
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_data <= '0;
      o_data_valid <= 1'b0;
      o_wr_line_done <= 1'b0;
      o_rd_line_done <= 1'b0;
    end else begin
      state <= state_nx;
      if (wr_acc) wr_ptr <= wr_last ? '0 : wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_last ? '0 : rd_ptr + 1'b1;
      if (rd_acc) o_data <= rdata;
      o_data_valid <= rd_acc;
      o_wr_line_done <= wr_acc && wr_last;
      o_rd_line_done <= rd_acc && rd_last;
    end
  end
endmodule

// File: tb/tb_line_buffer_win.sv
// tb_line_buffer_win: directed self-checking bench for line_buffer_win at widths 8 and 6
module tb_line_buffer_win;
  logic clk = 1'b0, rst = 1'b1;
  logic dv8 = 1'b0, rd8 = 1'b0, dv6 = 1'b0, rd6 = 1'b0;
  logic [7:0] d8 = '0, d6 = '0;
  logic wr_rdy8, rd_rdy8, qv8, wld8, rld8, wr_rdy6, rd_rdy6, qv6, wld6, rld6;
  logic [23:0] q8, q6;
  int vectors = 0, miscompares = 0;
`ifdef LINEBUF_CLAMP_EN
  int t8 [8][3] = '{'{0,1,2}, '{1,2,3}, '{2,3,4}, '{3,4,5}, '{4,5,6}, '{5,6,7}, '{6,7,7}, '{7,7,7}};
  int t6 [6][3] = '{'{0,1,2}, '{1,2,3}, '{2,3,4}, '{3,4,5}, '{4,5,5}, '{5,5,5}};
`else
  int t8 [8][3] = '{'{0,1,2}, '{1,2,3}, '{2,3,4}, '{3,4,5}, '{4,5,6}, '{5,6,7}, '{6,7,0}, '{7,0,1}};
  int t6 [6][3] = '{'{0,1,2}, '{1,2,3}, '{2,3,4}, '{3,4,5}, '{4,5,0}, '{5,0,1}};
`endif
  always #5 clk = ~clk;

  line_buffer_win #(.PIXEL_W(8), .IMAGE_WIDTH(8), .WINDOW(3)) u8 (
    .i_clk(clk), .i_rst(rst), .i_data_valid(dv8), .i_data(d8), .o_wr_ready(wr_rdy8),
    .i_rd_data(rd8), .o_rd_ready(rd_rdy8), .o_data(q8), .o_data_valid(qv8),
    .o_wr_line_done(wld8), .o_rd_line_done(rld8)
  );
  line_buffer_win #(.PIXEL_W(8), .IMAGE_WIDTH(6), .WINDOW(3)) u6 (
    .i_clk(clk), .i_rst(rst), .i_data_valid(dv6), .i_data(d6), .o_wr_ready(wr_rdy6),
    .i_rd_data(rd6), .o_rd_ready(rd_rdy6), .o_data(q6), .o_data_valid(qv6),
    .o_wr_line_done(wld6), .o_rd_line_done(rld6)
  );

  function automatic logic [23:0] w8(input int b, input int p);
    return {8'(b + t8[p][0]), 8'(b + t8[p][1]), 8'(b + t8[p][2])};
  endfunction
  function automatic logic [23:0] w6(input int b, input int p);
    return {8'(b + t6[p][0]), 8'(b + t6[p][1]), 8'(b + t6[p][2])};
  endfunction

  task automatic fill8(input int base);
    for (int i = 0; i < 8; i++) begin
      dv8 = 1'b1; d8 = 8'(base + i);
      @(posedge clk); #1;
    end
    dv8 = 1'b0;
  endtask

  task automatic test_reset;
    vectors++;
    if ({wr_rdy8, rd_rdy8, qv8, wld8, rld8, q8} !== {5'b10000, 24'h0}) begin
      miscompares++; $display("FAIL reset8 got %b/%h want 10000/000000", {wr_rdy8, rd_rdy8, qv8, wld8, rld8}, q8);
    end
    vectors++;
    if ({wr_rdy6, rd_rdy6, qv6, wld6, rld6, q6} !== {5'b10000, 24'h0}) begin
      miscompares++; $display("FAIL reset6 got %b/%h want 10000/000000", {wr_rdy6, rd_rdy6, qv6, wld6, rld6}, q6);
    end
  endtask

  task automatic test_fill_handshake;
    for (int i = 0; i < 8; i++) begin
      dv8 = 1'b1; d8 = 8'(i); rd8 = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (qv8 !== 1'b0) begin
        miscompares++; $display("FAIL rd_in_fill cycle %0d got valid %b want 0", i, qv8);
      end
      vectors++;
      if (wld8 !== (i == 7)) begin
        miscompares++; $display("FAIL wr_line_done cycle %0d got %b want %b", i, wld8, i == 7);
      end
    end
    rd8 = 1'b0;
    vectors++;
    if ({wr_rdy8, rd_rdy8} !== 2'b01) begin
      miscompares++; $display("FAIL ready_flip got wr/rd %b want 01", {wr_rdy8, rd_rdy8});
    end
    for (int i = 0; i < 2; i++) begin
      dv8 = 1'b1; d8 = 8'hFF;
      @(posedge clk); #1;
      vectors++;
      if ({wld8, qv8, wr_rdy8, rd_rdy8} !== 4'b0001) begin
        miscompares++; $display("FAIL write_in_ready got done/valid/wr/rd %b want 0001", {wld8, qv8, wr_rdy8, rd_rdy8});
      end
    end
    dv8 = 1'b0;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      rd8 = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (qv8 !== 1'b1 || q8 !== w8(0, i) || rld8 !== (i == 7)) begin
        miscompares++; $display("FAIL b2b window %0d got v=%b d=%h ld=%b want v=1 d=%h ld=%b", i, qv8, q8, rld8, w8(0, i), i == 7);
      end
    end
    rd8 = 1'b0;
    vectors++;
    if ({wr_rdy8, rd_rdy8} !== 2'b10) begin
      miscompares++; $display("FAIL back_to_fill got wr/rd %b want 10", {wr_rdy8, rd_rdy8});
    end
    rd8 = 1'b1;
    @(posedge clk); #1;
    rd8 = 1'b0;
    vectors++;
    if (qv8 !== 1'b0 || rld8 !== 1'b0 || q8 !== w8(0, 7)) begin
      miscompares++; $display("FAIL hold_after_line got v=%b ld=%b d=%h want v=0 ld=0 d=%h", qv8, rld8, q8, w8(0, 7));
    end
  endtask

  task automatic test_gaps;
    int i, nv, cyc;
    logic acc;
    i = 0; cyc = 0;
    while (i < 8 && cyc < 100) begin
      dv8 = $urandom_range(0, 2) != 0; d8 = 8'(40 + i);
      acc = dv8 && wr_rdy8;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    dv8 = 1'b0;
    vectors++;
    if (i != 8) begin
      miscompares++; $display("FAIL gap_fill timeout wrote %0d want 8", i);
    end
    nv = 0; cyc = 0;
    while (nv < 8 && cyc < 200) begin
      rd8 = rd_rdy8 && ($urandom_range(0, 2) != 0);
      acc = rd8;
      @(posedge clk); #1;
      vectors++;
      if (qv8 !== acc) begin
        miscompares++; $display("FAIL gap_valid got %b want %b", qv8, acc);
      end
      if (qv8 === 1'b1) begin
        vectors++;
        if (q8 !== w8(40, nv) || rld8 !== (nv == 7)) begin
          miscompares++; $display("FAIL gap_window %0d got d=%h ld=%b want d=%h ld=%b", nv, q8, rld8, w8(40, nv), nv == 7);
        end
        nv++;
      end
      cyc++;
    end
    rd8 = 1'b0;
    vectors++;
    if (nv != 8) begin
      miscompares++; $display("FAIL gap_drain timeout got %0d windows want 8", nv);
    end
  endtask

  task automatic test_async_reset;
    fill8(0);
    for (int i = 0; i < 3; i++) begin
      rd8 = 1'b1;
      @(posedge clk); #1;
    end
    rd8 = 1'b0;
    vectors++;
    if (q8 !== w8(0, 2)) begin
      miscompares++; $display("FAIL pre_reset window got %h want %h", q8, w8(0, 2));
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({qv8, wr_rdy8, rd_rdy8} !== 3'b010 || q8 !== 24'h0) begin
      miscompares++; $display("FAIL async_reset got v/wr/rd %b d=%h want 010 d=000000", {qv8, wr_rdy8, rd_rdy8}, q8);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    fill8(10);
    rd8 = 1'b1;
    @(posedge clk); #1;
    rd8 = 1'b0;
    vectors++;
    if (qv8 !== 1'b1 || q8 !== 24'h0A0B0C) begin
      miscompares++; $display("FAIL refill_window got v=%b d=%h want v=1 d=0a0b0c", qv8, q8);
    end
  endtask

  task automatic test_non_pow2;
    for (int ln = 0; ln < 2; ln++) begin
      for (int i = 0; i < 6; i++) begin
        dv6 = 1'b1; d6 = 8'(ln * 20 + i);
        @(posedge clk); #1;
      end
      dv6 = 1'b0;
      vectors++;
      if ({wld6, wr_rdy6, rd_rdy6} !== 3'b101) begin
        miscompares++; $display("FAIL np2_fill line %0d got done/wr/rd %b want 101", ln, {wld6, wr_rdy6, rd_rdy6});
      end
      for (int i = 0; i < 6; i++) begin
        rd6 = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (qv6 !== 1'b1 || q6 !== w6(ln * 20, i) || rld6 !== (i == 5)) begin
          miscompares++; $display("FAIL np2 line %0d window %0d got v=%b d=%h ld=%b want v=1 d=%h ld=%b", ln, i, qv6, q6, rld6, w6(ln * 20, i), i == 5);
        end
      end
      rd6 = 1'b0;
    end
    vectors++;
    if ({wr_rdy6, rd_rdy6} !== 2'b10) begin
      miscompares++; $display("FAIL np2_end got wr/rd %b want 10", {wr_rdy6, rd_rdy6});
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    rst = 1'b0;
    test_fill_handshake;
    test_back_to_back;
    test_gaps;
    test_async_reset;
    test_non_pow2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
